system1_input1: RTL
===================

SYSTEM1_INPUT1 -- requirements
Module: system1_input1

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of in_port, data register, mask and edge-capture register; legal range 1-32.
REQ-002 Parameter EDGE_TYPE, default 0: edge detected per bit; 0 = rising, 1 = falling, 2 = any.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth on in_port; legal range 2-3.
REQ-004 Port clk, input, 1: single clock, all logic on rising edge.
REQ-005 Port reset, input, 1: one clock; reset is synchronous and active-high.
REQ-006 Port address, input, 2: Avalon-MM word address.
REQ-007 Port chipselect, input, 1: slave select.
REQ-008 Port read_n, input, 1: active-low read strobe, qualified by chipselect.
REQ-009 Port write_n, input, 1: active-low write strobe, qualified by chipselect.
REQ-010 Port writedata, input, 32: write data.
REQ-011 Port in_port, input, DATA_WIDTH: asynchronous external inputs.
REQ-012 Port readdata, output, 32: registered read data.
REQ-013 Port irq, output, 1: level interrupt request, active-high.

Function
REQ-014 in_port SHALL pass through SYNC_STAGES flops; the last stage is sync_q, plus one extra delay flop sync_d for edge detection.
REQ-015 Register map: 0 = data (sync_q, read-only), 1 = reserved (reads 0, writes ignored), 2 = irq mask (R/W), 3 = edge capture (read, write-1-to-clear).
REQ-016 Per-bit edge event: rising = sync_q & ~sync_d; falling = ~sync_q & sync_d; any = sync_q ^ sync_d; selected by EDGE_TYPE.
REQ-017 An edge-capture bit SHALL set on the clock edge after its event and hold until cleared.
REQ-018 Write to address 3 SHALL clear each bit where writedata is 1; bits where writedata is 0 unchanged.
REQ-019 Same-cycle event and clear on one bit: set wins; bit reads 1 afterwards.
REQ-020 Write to address 2 SHALL load mask from writedata[DATA_WIDTH-1:0] on the same clock edge.
REQ-021 Writes to address 0 or 1 SHALL have no effect.
REQ-022 Read latency SHALL be exactly 1: readdata is updated on the clock edge where chipselect & ~read_n is sampled.
REQ-023 readdata SHALL hold its value between reads; unused upper bits read 0.
REQ-024 Read of address 3 SHALL NOT clear edge capture.
REQ-025 irq SHALL be registered: irq = OR of (edge_capture & mask) of the previous cycle, i.e. one cycle after the bit sets or the mask write.
REQ-026 Clearing all masked capture bits SHALL deassert irq one cycle after the clearing write.
REQ-027 Read and write asserted together: write takes effect; readdata returns the pre-write value.
REQ-028 Latency from an in_port transition to the capture bit set SHALL be SYNC_STAGES+1 clocks.

Reset
REQ-029 While reset is high at a clock edge, all synchronizer flops, sync_d, mask, edge capture, readdata and irq SHALL be 0.
REQ-030 Bus accesses during reset SHALL be ignored.
REQ-031 After reset deasserts, no edge SHALL be reported for an in_port already high (sync_d equals sync_q when released).
REQ-032 Reset asserted mid-operation SHALL discard pending captures and deassert irq at the next edge.

Verification
REQ-033 in_port=0x0000_00A5 held 4 clocks, read addr 0 -> readdata 0x0000_00A5 one clock after the read strobe.
REQ-034 EDGE_TYPE=0, mask=0x1, in_port bit0 0->1 -> capture=0x1 after 3 clocks, irq=1 one clock later; write 0x1 to addr 3 -> irq=0 next clock.
REQ-035 mask=0, rising edge on bit4 -> capture reads 0x10, irq stays 0; then write mask=0x10 -> irq=1 one clock after the write.
REQ-036 Edge on bit2 in the same cycle as a clear write of 0x4 -> capture bit2 reads 1.
REQ-037 Captures=0xF, write 0x5 to addr 3 -> capture reads 0xA; write to addr 0 -> data unaffected.
REQ-038 Reset pulse with in_port=0xFFFF_FFFF, mask=0xFFFF_FFFF set beforehand -> after release all registers 0, irq 0, no capture over 10 clocks.

Source files
------------

// File: rtl/system1_input1.sv
// Avalon-MM parallel input port: synchronized inputs, per-bit edge capture
// with write-1-to-clear, interrupt mask and a registered level interrupt.
module system1_input1 #(
  parameter int DATA_WIDTH  = 32,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES + 1);

  logic [DATA_WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_q_s;
  logic [DATA_WIDTH-1:0] sync_d_r;
  logic [DATA_WIDTH-1:0] mask_r;
  logic [DATA_WIDTH-1:0] capture_r;
  logic [DATA_WIDTH-1:0] raw_event_s;
  logic [DATA_WIDTH-1:0] event_s;
  logic [2:0]            prime_cnt_r;
  logic                  primed_s;
  logic                  rd_s;
  logic                  wr_s;
  logic [31:0]           rd_mux_s;

  function automatic logic [31:0] pad32(input logic [DATA_WIDTH-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[DATA_WIDTH-1:0] = v;
    return r;
  endfunction

  assign sync_q_s = sync_r[SYNC_STAGES-1];
  assign primed_s = (prime_cnt_r == PRIME_LAST);
  assign rd_s     = chipselect & ~read_n;
  assign wr_s     = chipselect & ~write_n;

  // Edge event selection; suppressed until the synchronizer has refilled after
  // reset so inputs already high at release do not look like rising edges.
  always_comb begin
    case (EDGE_TYPE)
      0:       raw_event_s = sync_q_s & ~sync_d_r;
      1:       raw_event_s = ~sync_q_s & sync_d_r;
      default: raw_event_s = sync_q_s ^ sync_d_r;
    endcase
    if (primed_s) begin
      event_s = raw_event_s;
    end else begin
      event_s = '0;
    end
  end

  // Read data selection from current (pre-write) register values
  always_comb begin
    case (address)
      2'd0:    rd_mux_s = pad32(sync_q_s);
      2'd2:    rd_mux_s = pad32(mask_r);
      2'd3:    rd_mux_s = pad32(capture_r);
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Synchronizer chain, edge-detect delay flop and post-reset priming counter
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
      sync_d_r    <= '0;
      prime_cnt_r <= 3'd0;
    end else begin
      sync_r[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      sync_d_r <= sync_q_s;
      if (!primed_s) begin
        prime_cnt_r <= prime_cnt_r + 3'd1;
      end else begin
        prime_cnt_r <= prime_cnt_r;
      end
    end
  end

  // Register file, edge capture (set wins over clear), readback and irq
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_r    <= '0;
      capture_r <= '0;
      readdata  <= 32'd0;
      irq       <= 1'b0;
    end else begin
      if (wr_s && address == 2'd2) begin
        mask_r <= writedata[DATA_WIDTH-1:0];
      end else begin
        mask_r <= mask_r;
      end
      if (wr_s && address == 2'd3) begin
        capture_r <= (capture_r & ~writedata[DATA_WIDTH-1:0]) | event_s;
      end else begin
        capture_r <= capture_r | event_s;
      end
      if (rd_s) begin
        readdata <= rd_mux_s;
      end else begin
        readdata <= readdata;
      end
      irq <= |(capture_r & mask_r);
    end
  end

endmodule
